// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver for the servant SoC.
//
// The rx line is brought into the wb_clk domain by a two-flop synchronizer.
// A five-state FSM then finds the start edge, confirms it at mid-bit,
// samples 8 data bits LSB first and checks the stop bit. Completed bytes go
// into a receive buffer that the consumer drains through a valid/ready port.
//
// Build option: define SERVANT_UART_RX_FIFO_EN to make the receive buffer a
// FIFO_DEPTH-entry FIFO. Without it the buffer is one holding register.
//
// Handshake: rvalid is high while rdata holds the byte at the buffer head.
// The byte is consumed on a rising wb_clk edge where rvalid && rready.
// While rvalid && !rready, rdata does not change. rready has no effect
// while rvalid is low.
//
// Debug: state_dbg shows the FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP,
// 4 WAIT_HIGH).
module servant_uart_rx #(
  parameter int CLK_FREQ_HZ = 32000000,
  parameter int BAUD_RATE   = 57600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

  // Last count of a full bit period, and of the half period used to reach
  // the middle of the start bit.
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic          push;
  logic          fe_d;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          buf_full;
  logic          frame_err_q;
  logic          overrun_q;

  // Two-flop synchronizer. It resets to the idle-high line level.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // FSM state, bit-period counter, bit index and shift register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic. It produces the push strobe at the stop sample and
  // the frame-error request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        // A break, or a line stuck low, must go high before the next frame.
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign state_dbg = state_q;

  // Buffer control. A push into a full buffer still succeeds when a pop
  // frees the head entry on the same edge.
  assign pop     = rvalid && rready;
  assign push_ok = push && (!buf_full || pop);
  assign drop    = push && buf_full && !pop;

`ifdef SERVANT_UART_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        buf_empty;

  // The pointers carry one extra wrap bit. Equal addresses with different
  // wrap bits mean full; identical pointers mean empty.
  assign buf_empty = (wr_q == rd_q);
  assign buf_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rvalid    = !buf_empty;
  assign rdata     = mem_q[rd_q[AW-1:0]];

  // FIFO storage and wrap-around read/write pointers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= shift_q;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_full_q;

  assign buf_full = hold_full_q;
  assign rvalid   = hold_full_q;
  assign rdata    = hold_q;

  // Single holding register. A pop and a push on the same edge replace the
  // byte.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (push_ok) begin
        hold_q      <= shift_q;
        hold_full_q <= 1'b1;
      end else if (pop) begin
        hold_full_q <= 1'b0;
      end
    end
  end
`endif

  // Error pulses are registered so that each event gives exactly one clean
  // cycle. Frames are far longer than one cycle, so two pulses can never
  // touch.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= fe_d;
      overrun_q   <= drop;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: self-checking bench for servant_uart_rx at 16 clocks
// per bit. A negedge monitor logs every accepted byte and every error pulse.
// Each test task compares those logs against bytes and counts derived from
// the serial traffic it sent.
`timescale 1ns/1ps
module tb_servant_uart_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef SERVANT_UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  // Debug encoding of the idle state on state_dbg.
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       wb_clk;
  logic       wb_rst;
  logic       rx;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // Monitor logs. Only the monitor writes these.
  logic [7:0] got_q[$];
  int   fe_cnt = 0, fe_long = 0, ov_cnt = 0, ov_long = 0;
  int   rv_cnt = 0, stab_err = 0;
  logic fe_prev = 0, ov_prev = 0, hold_prev = 0;
  logic [7:0] rdata_prev = 0;

  servant_uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .rx       (rx),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // Monitor. Inputs change just after a posedge, so the values seen at a
  // negedge are the ones the next posedge acts on.
  always @(negedge wb_clk) begin
    if (wb_rst) begin
      fe_prev   = 1'b0;
      ov_prev   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (rvalid && rready) got_q.push_back(rdata);
      if (rvalid) rv_cnt++;
      if (frame_err) begin
        fe_cnt++;
        if (fe_prev) fe_long++;
      end
      if (overrun) begin
        ov_cnt++;
        if (ov_prev) ov_long++;
      end
      if (hold_prev && rvalid && (rdata !== rdata_prev)) stab_err++;
      fe_prev    = frame_err;
      ov_prev    = overrun;
      hold_prev  = rvalid && !rready;
      rdata_prev = rdata;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    rx     = 1'b1;
    rready = 1'b0;
    tick(3);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    wb_rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single();
    int base, rv0, fe0, ov0;
    base = got_q.size(); rv0 = rv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    rready = 1'b1;
    send_frame(8'h55, 1'b1);
    tick(10);
    total++; if (got_q.size() - base != 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size() - base); end
    else begin
      total++; if (got_q[base] !== 8'h55) begin bad++; $display("FAIL single_data: got %h want 55", got_q[base]); end
    end
    total++; if (rv_cnt - rv0 != 1) begin bad++; $display("FAIL single_rvalid_cycles: got %0d want 1", rv_cnt - rv0); end
    total++; if (fe_cnt - fe0 + ov_cnt - ov0 != 0) begin bad++; $display("FAIL single_err_pulses: got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int base, ov0;
    base = got_q.size(); ov0 = ov_cnt;
    rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    tick(10);
    total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[base+i] !== exp_q[i]) begin bad++; $display("FAIL random_data[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]); end
      end
    end
    total++; if (ov_cnt != ov0) begin bad++; $display("FAIL random_overrun: got %0d want 0", ov_cnt - ov0); end
  endtask

  // Random backpressure. Each byte has a whole frame time to be drained, so
  // every byte must arrive, in order, with no overrun.
  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int base, ov0, st0;
    bit done;
    base = got_q.size(); ov0 = ov_cnt; st0 = stab_err;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_frame(b, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rready = 1'b1;
    tick(20);
    total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[base+i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]); end
      end
    end
    total++; if (ov_cnt != ov0) begin bad++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt - ov0); end
    total++; if (stab_err != st0) begin bad++; $display("FAIL b2b_rdata_stable: got %0d changes want 0", stab_err - st0); end
  endtask

  task automatic test_overrun();
    int base, ov0, ol0, n_keep;
    base = got_q.size(); ov0 = ov_cnt; ol0 = ov_long;
    rready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    tick(10);
    n_keep = (DEPTH < 5) ? DEPTH : 5;
    total++; if (ov_cnt - ov0 != 5 - n_keep) begin bad++; $display("FAIL overrun_pulses: got %0d want %0d", ov_cnt - ov0, 5 - n_keep); end
    total++; if (ov_long != ol0) begin bad++; $display("FAIL overrun_width: got %0d long pulses want 0", ov_long - ol0); end
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL overrun_rvalid_held: got %b want 1", rvalid); end
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL overrun_head: got %h want 01", rdata); end
    rready = 1'b1;
    tick(10);
    rready = 1'b0;
    total++; if (got_q.size() - base != n_keep) begin bad++; $display("FAIL drain_count: got %0d want %0d", got_q.size() - base, n_keep); end
    else begin
      for (int i = 0; i < n_keep; i++) begin
        total++; if (got_q[base+i] !== 8'(i + 1)) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, got_q[base+i], 8'(i + 1)); end
      end
    end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", rvalid); end
  endtask

  task automatic test_glitch();
    int base, fe0, ov0;
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    rready = 1'b1;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    total++; if (got_q.size() != base) begin bad++; $display("FAIL glitch_push: got %0d bytes want 0", got_q.size() - base); end
    total++; if (fe_cnt + ov_cnt != fe0 + ov0) begin bad++; $display("FAIL glitch_err: got %0d pulses want 0", fe_cnt + ov_cnt - fe0 - ov0); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL glitch_state: got %0d want %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_frame_err();
    int base, fe0, fl0;
    base = got_q.size(); fe0 = fe_cnt; fl0 = fe_long;
    rready = 1'b1;
    send_frame(8'hA5, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(20);
    send_frame(8'h3C, 1'b1);
    tick(20);
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0); end
    total++; if (fe_long != fl0) begin bad++; $display("FAIL frame_err_width: got %0d long pulses want 0", fe_long - fl0); end
    total++; if (got_q.size() - base != 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", got_q.size() - base); end
    else begin
      total++; if (got_q[base] !== 8'h3C) begin bad++; $display("FAIL frame_err_data: got %h want 3c", got_q[base]); end
    end
  endtask

  task automatic test_mid_reset();
    int base, fe0;
    // Leave a byte waiting in the buffer; reset must discard it.
    rready = 1'b0;
    send_frame(8'h77, 1'b1);
    tick(5);
    base = got_q.size(); fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    tick(CPB / 2);
    wb_rst = 1'b1;
    tick(2);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid: got %b want 0", rvalid); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata: got %h want 00", rdata); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL midrst_pulses: got %b%b want 00", frame_err, overrun); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL midrst_state: got %0d want %0d", state_dbg, ST_IDLE); end
    wb_rst = 1'b0;
    rready = 1'b1;
    tick(CPB * 6);
    send_frame(8'h12, 1'b1);
    tick(20);
    total++; if (got_q.size() - base != 1) begin bad++; $display("FAIL midrst_count: got %0d want 1", got_q.size() - base); end
    else begin
      total++; if (got_q[base] !== 8'h12) begin bad++; $display("FAIL midrst_data: got %h want 12", got_q[base]); end
    end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL midrst_frame_err: got %0d want 0", fe_cnt - fe0); end
  endtask

  initial begin
    wb_rst = 1'b1;
    rx     = 1'b1;
    rready = 1'b0;
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
